// File: rtl/ternary_mlp_engine.sv
// Time-multiplexed ternary MLP: evaluates NUM_LAYERS fully-connected ternary layers and reports the final-layer argmax.
// Optional: define TERNARY_MLP_ABORT_EN so that start while busy aborts the current run and restarts it.
module ternary_mlp_engine #(
    parameter int NUM_LAYERS        = 3,
    parameter int MAX_NEURONS       = 1024,
    parameter int PAR               = 64,
    parameter int WEIGHT_DATA_WIDTH = 2,
    parameter int BIAS_DATA_WIDTH   = 2,
    parameter int WEIGHT_ADDR_WIDTH = 16,
    parameter int BIAS_ADDR_WIDTH   = 12,
    parameter int ACC_WIDTH         = 12,
    localparam int NW = $clog2(MAX_NEURONS + 1),
    localparam int IW = $clog2(MAX_NEURONS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NW-1:0]                    cfg_num_inputs,
    input  logic [NUM_LAYERS*NW-1:0]         cfg_neurons,
    input  logic [MAX_NEURONS-1:0]           in_vec,
    output logic [WEIGHT_ADDR_WIDTH-1:0]     weight_addr,
    output logic                             weight_ren,
    input  logic [PAR*WEIGHT_DATA_WIDTH-1:0] weight_data,
    output logic [BIAS_ADDR_WIDTH-1:0]       bias_addr,
    output logic                             bias_ren,
    input  logic [BIAS_DATA_WIDTH-1:0]       bias_data,
    output logic                             busy,
    output logic                             done,
    output logic [IW-1:0]                    class_idx,
    output logic [ACC_WIDTH-1:0]             class_score
);

    localparam int MAX_CHUNKS = (MAX_NEURONS + PAR - 1) / PAR;
    localparam int CHW        = $clog2(MAX_CHUNKS + 1);
    localparam int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int XW         = $clog2(MAX_NEURONS + PAR) + 1;

    typedef enum logic [2:0] {IDLE, FETCH, FINAL, LAYER, DONE} state_t;

    state_t                 state;
    logic [MAX_NEURONS-1:0] act_a;
    logic [MAX_NEURONS-1:0] act_b;
    logic                   sel;
    logic [LW-1:0]          layer;
    logic [IW-1:0]          neuron;
    logic [CHW-1:0]         chunk;
    logic [ACC_WIDTH-1:0]   acc;
    logic [NW-1:0]          num_inputs_r;
    logic [NW-1:0]          neurons_r [NUM_LAYERS];
    logic [IW-1:0]          best_idx;
    logic [ACC_WIDTH-1:0]   best_score;

    logic [NW-1:0]          start_inputs;
    logic [CHW-1:0]         start_chunks;
    logic [NW-1:0]          cur_inputs;
    logic [NW-1:0]          cur_neurons;
    logic [CHW-1:0]         cur_chunks;
    logic [CHW-1:0]         next_layer_chunks;
    logic [CHW-1:0]         data_chunk;
    logic [MAX_NEURONS-1:0] cur_act;
    logic                   last_chunk;
    logic                   last_neuron;
    logic                   last_layer;
    logic                   launch;
    logic [ACC_WIDTH-1:0]   lane_sum;
    logic [XW-1:0]          lane_idx;
    logic [WEIGHT_DATA_WIDTH-1:0] lane_w;
    logic                   lane_pos;
    logic [ACC_WIDTH-1:0]   bias_ext;
    logic [ACC_WIDTH-1:0]   final_sum;
    logic                   is_better;

    // Zero counts become 1 and oversized counts saturate at MAX_NEURONS.
    function automatic logic [NW-1:0] clamp_count(input logic [NW-1:0] c);
        if (c == '0) return NW'(1);
        if (c > NW'(MAX_NEURONS)) return NW'(MAX_NEURONS);
        return c;
    endfunction

    function automatic logic [CHW-1:0] chunks_of(input logic [NW-1:0] n);
        return CHW'((int'(n) + PAR - 1) / PAR);
    endfunction

    always_comb begin
        cur_inputs = num_inputs_r;
        if (layer != '0) cur_inputs = neurons_r[layer - LW'(1)];
    end

    assign start_inputs      = clamp_count(cfg_num_inputs);
    assign start_chunks      = chunks_of(start_inputs);
    assign cur_neurons       = neurons_r[layer];
    assign cur_chunks        = chunks_of(cur_inputs);
    assign next_layer_chunks = chunks_of(cur_neurons);
    assign cur_act           = sel ? act_b : act_a;
    assign last_chunk        = (chunk == cur_chunks - CHW'(1));
    assign last_neuron       = (NW'(neuron) == cur_neurons - NW'(1));
    assign last_layer        = (layer == LW'(NUM_LAYERS - 1));

`ifdef TERNARY_MLP_ABORT_EN
    assign launch = start && (state == IDLE || busy);
`else
    assign launch = start && (state == IDLE);
`endif

    // Read data lags the request by one cycle, so FETCH consumes the previous chunk.
    assign data_chunk = (state == FINAL) ? chunk : chunk - CHW'(1);

    always_comb begin
        lane_sum = '0;
        lane_idx = '0;
        lane_w   = '0;
        lane_pos = 1'b0;
        for (int j = 0; j < PAR; j++) begin
            lane_idx = XW'(data_chunk) * XW'(PAR) + XW'(j);
            lane_w   = weight_data[j*WEIGHT_DATA_WIDTH +: WEIGHT_DATA_WIDTH];
            if (lane_idx < XW'(cur_inputs) &&
                (lane_w == WEIGHT_DATA_WIDTH'(1) || lane_w == WEIGHT_DATA_WIDTH'(3))) begin
                lane_pos = ((lane_w == WEIGHT_DATA_WIDTH'(1)) == cur_act[lane_idx[IW-1:0]]);
                lane_sum = lane_pos ? lane_sum + ACC_WIDTH'(1) : lane_sum - ACC_WIDTH'(1);
            end
        end
    end

    assign bias_ext  = {{(ACC_WIDTH-BIAS_DATA_WIDTH){bias_data[BIAS_DATA_WIDTH-1]}}, bias_data};
    assign final_sum = acc + lane_sum + bias_ext;
    assign is_better = (neuron == '0) || ($signed(final_sum) > $signed(best_score));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            act_a        <= '0;
            act_b        <= '0;
            sel          <= 1'b0;
            layer        <= '0;
            neuron       <= '0;
            chunk        <= '0;
            acc          <= '0;
            num_inputs_r <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) neurons_r[i] <= '0;
            best_idx     <= '0;
            best_score   <= '0;
            weight_addr  <= '0;
            weight_ren   <= 1'b0;
            bias_addr    <= '0;
            bias_ren     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            class_idx    <= '0;
            class_score  <= '0;
        end else if (launch) begin
            act_a        <= in_vec;
            sel          <= 1'b0;
            num_inputs_r <= start_inputs;
            for (int i = 0; i < NUM_LAYERS; i++) neurons_r[i] <= clamp_count(cfg_neurons[i*NW +: NW]);
            layer        <= '0;
            neuron       <= '0;
            chunk        <= '0;
            acc          <= '0;
            weight_addr  <= '0;
            bias_addr    <= '0;
            weight_ren   <= 1'b1;
            bias_ren     <= (start_chunks == CHW'(1));
            busy         <= 1'b1;
            done         <= 1'b0;
            state        <= FETCH;
        end else begin
            case (state)
                FETCH: begin
                    weight_addr <= weight_addr + WEIGHT_ADDR_WIDTH'(1);
                    if (bias_ren) bias_addr <= bias_addr + BIAS_ADDR_WIDTH'(1);
                    if (chunk != '0) acc <= acc + lane_sum;
                    if (last_chunk) begin
                        weight_ren <= 1'b0;
                        bias_ren   <= 1'b0;
                        state      <= FINAL;
                    end else begin
                        chunk      <= chunk + CHW'(1);
                        weight_ren <= 1'b1;
                        bias_ren   <= ((chunk + CHW'(1)) == (cur_chunks - CHW'(1)));
                    end
                end
                FINAL: begin
                    acc <= '0;
                    if (sel) act_a[neuron] <= ~final_sum[ACC_WIDTH-1];
                    else     act_b[neuron] <= ~final_sum[ACC_WIDTH-1];
                    if (last_layer && is_better) begin
                        best_idx   <= neuron;
                        best_score <= final_sum;
                    end
                    if (last_layer && last_neuron) begin
                        class_idx   <= is_better ? neuron : best_idx;
                        class_score <= is_better ? final_sum : best_score;
                    end
                    if (last_neuron) begin
                        state <= LAYER;
                    end else begin
                        neuron     <= neuron + IW'(1);
                        chunk      <= '0;
                        weight_ren <= 1'b1;
                        bias_ren   <= (cur_chunks == CHW'(1));
                        state      <= FETCH;
                    end
                end
                LAYER: begin
                    sel    <= ~sel;
                    neuron <= '0;
                    chunk  <= '0;
                    if (last_layer) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        layer      <= layer + LW'(1);
                        weight_ren <= 1'b1;
                        bias_ren   <= (next_layer_chunks == CHW'(1));
                        state      <= FETCH;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_mlp_engine.sv
// Directed self-checking bench for ternary_mlp_engine (MAX_NEURONS=8, PAR=4, NUM_LAYERS=2).
module tb_ternary_mlp_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  cfg_num_inputs = '0;
    logic [7:0]  cfg_neurons = '0;
    logic [7:0]  in_vec = '0;
    logic [15:0] weight_addr;
    logic        weight_ren;
    logic [7:0]  weight_data = '0;
    logic [11:0] bias_addr;
    logic        bias_ren;
    logic [1:0]  bias_data = '0;
    logic        busy;
    logic        done;
    logic [2:0]  class_idx;
    logic [11:0] class_score;

    int checks = 0;
    int failures = 0;
    logic [7:0] wmem [0:63];
    logic [1:0] bmem [0:63];
    int waddr_log [$];
    int baddr_log [$];
    logic busy_at_1;
    logic [14:0] mid_class;

    ternary_mlp_engine #(
        .NUM_LAYERS(2), .MAX_NEURONS(8), .PAR(4), .WEIGHT_DATA_WIDTH(2), .BIAS_DATA_WIDTH(2),
        .WEIGHT_ADDR_WIDTH(16), .BIAS_ADDR_WIDTH(12), .ACC_WIDTH(12)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_inputs(cfg_num_inputs),
        .cfg_neurons(cfg_neurons), .in_vec(in_vec), .weight_addr(weight_addr),
        .weight_ren(weight_ren), .weight_data(weight_data), .bias_addr(bias_addr),
        .bias_ren(bias_ren), .bias_data(bias_data), .busy(busy), .done(done),
        .class_idx(class_idx), .class_score(class_score)
    );

    always #5 clk = ~clk;

    // Synchronous memories: data appears one cycle after the read enable.
    always @(posedge clk) begin
        if (weight_ren) weight_data <= wmem[weight_addr[5:0]];
        if (bias_ren) bias_data <= bmem[bias_addr[5:0]];
    end

    always @(negedge clk) begin
        if (weight_ren) waddr_log.push_back(int'(weight_addr));
        if (bias_ren) baddr_log.push_back(int'(bias_addr));
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic fill_mem(input logic [7:0] w, input logic [1:0] b);
        for (int i = 0; i < 64; i++) begin
            wmem[i] = w;
            bmem[i] = b;
        end
    endtask

    task automatic do_run(input logic [7:0] vec, input logic [3:0] ninp, input logic [7:0] neur,
                          input int restart_at, output int done_cyc);
        int cyc;
        @(negedge clk);
        waddr_log.delete();
        baddr_log.delete();
        in_vec = vec;
        cfg_num_inputs = ninp;
        cfg_neurons = neur;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_at_1 = busy;
        while (done !== 1'b1 && cyc < 200) begin
            start = (cyc == restart_at);
            if (cyc == 10) mid_class = {class_idx, class_score};
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        done_cyc = cyc;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({weight_addr, weight_ren, bias_addr, bias_ren, busy, done, class_idx, class_score} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_held_outputs: got wa=%0d wr=%b ba=%0d br=%b busy=%b done=%b idx=%0d score=%0d expected all 0",
                     weight_addr, weight_ren, bias_addr, bias_ren, busy, done, class_idx, class_score);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({weight_addr, weight_ren, bias_addr, bias_ren, busy, done, class_idx, class_score} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_released_outputs: got wa=%0d wr=%b busy=%b done=%b expected all 0",
                     weight_addr, weight_ren, busy, done);
        end
    endtask

    task automatic test_baseline();
        int d;
        fill_mem(8'h55, 2'b00);
        do_run(8'hFF, 4'd8, {4'd3, 4'd2}, 0, d);
        checks++;
        if (d !== 15) begin failures++; $display("[TB] FAIL baseline_done_cycle: got %0d expected 15", d); end
        checks++;
        if (busy_at_1 !== 1'b1) begin failures++; $display("[TB] FAIL baseline_busy: got %b expected 1", busy_at_1); end
        checks++;
        if (class_idx !== 3'd0) begin failures++; $display("[TB] FAIL baseline_class_idx: got %0d expected 0", class_idx); end
        checks++;
        if (class_score !== 12'd2) begin failures++; $display("[TB] FAIL baseline_class_score: got %0d expected 2", class_score); end
        checks++;
        if (waddr_log.size() !== 7) begin
            failures++;
            $display("[TB] FAIL baseline_weight_count: got %0d expected 7", waddr_log.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (waddr_log[i] !== i) begin failures++; $display("[TB] FAIL baseline_weight_addr[%0d]: got %0d expected %0d", i, waddr_log[i], i); end
            end
        end
        checks++;
        if (baddr_log.size() !== 5) begin
            failures++;
            $display("[TB] FAIL baseline_bias_count: got %0d expected 5", baddr_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (baddr_log[i] !== i) begin failures++; $display("[TB] FAIL baseline_bias_addr[%0d]: got %0d expected %0d", i, baddr_log[i], i); end
            end
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin failures++; $display("[TB] FAIL baseline_after_done: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        in_vec = 8'hFF;
        cfg_num_inputs = 4'd8;
        cfg_neurons = {4'd3, 4'd2};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midrun_busy: got %b expected 1", busy); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({weight_addr, weight_ren, bias_addr, bias_ren, busy, done} !== '0) begin
            failures++;
            $display("[TB] FAIL midrun_reset_ctrl: got wa=%0d wr=%b ba=%0d br=%b busy=%b done=%b expected all 0",
                     weight_addr, weight_ren, bias_addr, bias_ren, busy, done);
        end
        checks++;
        if ({class_idx, class_score} !== '0) begin
            failures++;
            $display("[TB] FAIL midrun_reset_class: got idx=%0d score=%0d expected 0 0", class_idx, class_score);
        end
    endtask

    task automatic test_padding_mask();
        int d;
        fill_mem(8'h00, 2'b00);
        for (int i = 0; i < 10; i++) wmem[i] = 8'h55;
        wmem[10] = 8'hFF;
        wmem[11] = 8'hFF;
        do_run(8'h00, 4'd8, {4'd1, 4'd5}, 0, d);
        checks++;
        if (d !== 21) begin failures++; $display("[TB] FAIL padding_done_cycle: got %0d expected 21", d); end
        checks++;
        if (class_idx !== 3'd0) begin failures++; $display("[TB] FAIL padding_class_idx: got %0d expected 0", class_idx); end
        checks++;
        if (class_score !== 12'd5) begin failures++; $display("[TB] FAIL padding_class_score: got %0d expected 5", class_score); end
    endtask

    task automatic test_bias_threshold();
        int d;
        fill_mem(8'h00, 2'b00);
        wmem[0] = 8'h05; wmem[1] = 8'h35; wmem[2] = 8'h01; wmem[3] = 8'h04;
        bmem[0] = 2'b10; bmem[1] = 2'b10; bmem[2] = 2'b00; bmem[3] = 2'b01;
        do_run(8'h0F, 4'd4, {4'd2, 4'd2}, 0, d);
        checks++;
        if (d !== 11) begin failures++; $display("[TB] FAIL bias_done_cycle: got %0d expected 11", d); end
        checks++;
        if (class_idx !== 3'd0) begin failures++; $display("[TB] FAIL bias_class_idx: got %0d expected 0", class_idx); end
        checks++;
        if (class_score !== 12'd1) begin failures++; $display("[TB] FAIL bias_class_score: got %0d expected 1", class_score); end
    endtask

    task automatic test_argmax_hold();
        int d;
        fill_mem(8'h55, 2'b00);
        wmem[4] = 8'h00; wmem[5] = 8'h05; wmem[6] = 8'h05;
        bmem[2] = 2'b11; bmem[3] = 2'b01; bmem[4] = 2'b01;
        do_run(8'hFF, 4'd8, {4'd3, 4'd2}, 0, d);
        checks++;
        if (d !== 15) begin failures++; $display("[TB] FAIL argmax_done_cycle: got %0d expected 15", d); end
        checks++;
        if (class_idx !== 3'd1) begin failures++; $display("[TB] FAIL argmax_class_idx: got %0d expected 1", class_idx); end
        checks++;
        if (class_score !== 12'd3) begin failures++; $display("[TB] FAIL argmax_class_score: got %0d expected 3", class_score); end
        repeat (6) @(negedge clk);
        checks++;
        if ({class_idx, class_score} !== {3'd1, 12'd3}) begin
            failures++;
            $display("[TB] FAIL argmax_hold: got idx=%0d score=%0d expected 1 3", class_idx, class_score);
        end
    endtask

    task automatic test_busy_start();
        int d;
        int exp_done;
        int exp_count;
        int exp_at4;
`ifdef TERNARY_MLP_ABORT_EN
        exp_done = 20;
        exp_count = 11;
        exp_at4 = 0;
`else
        exp_done = 15;
        exp_count = 7;
        exp_at4 = 4;
`endif
        fill_mem(8'h55, 2'b00);
        do_run(8'hFF, 4'd8, {4'd3, 4'd2}, 5, d);
        checks++;
        if (d !== exp_done) begin failures++; $display("[TB] FAIL busy_done_cycle: got %0d expected %0d", d, exp_done); end
        checks++;
        if (mid_class !== {3'd1, 12'd3}) begin
            failures++;
            $display("[TB] FAIL busy_class_held: got idx=%0d score=%0d expected 1 3", mid_class[14:12], mid_class[11:0]);
        end
        checks++;
        if (waddr_log.size() !== exp_count) begin
            failures++;
            $display("[TB] FAIL busy_weight_count: got %0d expected %0d", waddr_log.size(), exp_count);
        end else begin
            checks++;
            if (waddr_log[4] !== exp_at4) begin failures++; $display("[TB] FAIL busy_weight_addr4: got %0d expected %0d", waddr_log[4], exp_at4); end
            checks++;
            if (waddr_log[exp_count-1] !== 6) begin failures++; $display("[TB] FAIL busy_weight_last: got %0d expected 6", waddr_log[exp_count-1]); end
        end
        checks++;
        if ({class_idx, class_score} !== {3'd0, 12'd2}) begin
            failures++;
            $display("[TB] FAIL busy_class_new: got idx=%0d score=%0d expected 0 2", class_idx, class_score);
        end
    endtask

    initial begin
        fill_mem(8'h00, 2'b00);
        $display("[TB] starting ternary_mlp_engine bench");
        test_reset();
        test_baseline();
        test_reset_midrun();
        test_padding_mask();
        test_bias_threshold();
        test_argmax_hold();
        test_busy_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ternary_mlp_engine.md
Name: ternary_mlp_engine

Overview:
- Parametrised successor to the fixed 3-layer ternary core: one time-multiplexed datapath evaluates NUM_LAYERS fully-connected ternary layers with runtime-configurable sizes.
- Operates on binary activations with ternary weights and signed biases, streamed from external weight/bias memories.
- Produces an argmax class index and score on the final layer.
- Sits between the window-slider/input buffer and the system controller, replacing the hard-wired per-layer calculator.

Parameters:
- NUM_LAYERS, 3, number of layers evaluated per run.
- MAX_NEURONS, 1024, maximum inputs or neurons of any layer.
- PAR, 64, ternary weights consumed per chunk, one chunk per cycle.
- WEIGHT_DATA_WIDTH, 2, bits per ternary weight.
- BIAS_DATA_WIDTH, 2, signed bias width.
- WEIGHT_ADDR_WIDTH, 16, weight memory address width.
- BIAS_ADDR_WIDTH, 12, bias memory address width.
- ACC_WIDTH, 12, signed accumulator width; must be at least clog2(MAX_NEURONS)+2.
- Derived: NW = clog2(MAX_NEURONS+1); IW = clog2(MAX_NEURONS).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled in IDLE.
- cfg_num_inputs  in  NW  layer-0 input count.
- cfg_neurons  in  NUM_LAYERS*NW  neuron count per layer, layer 0 in the LSBs.
- in_vec  in  MAX_NEURONS  input activations; bit=1 means +1, bit=0 means -1.
- weight_addr  out  WEIGHT_ADDR_WIDTH  chunk address.
- weight_ren  out  1  chunk read enable.
- weight_data  in  PAR*WEIGHT_DATA_WIDTH  chunk, valid 1 cycle after weight_ren.
- bias_addr  out  BIAS_ADDR_WIDTH  neuron bias address.
- bias_ren  out  1  bias read enable.
- bias_data  in  BIAS_DATA_WIDTH  signed bias, valid 1 cycle after bias_ren.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- class_idx  out  IW  argmax neuron index of the final layer.
- class_score  out  ACC_WIDTH  argmax score (accumulator plus bias).

Behaviour:
- Reset: every output is 0; FSM in IDLE; activation buffers cleared.
- Start (start=1 in IDLE):
  - Latch in_vec into activation buffer A.
  - Latch cfg_* fields; a count of 0 is treated as 1, and a count above MAX_NEURONS is clamped to MAX_NEURONS.
  - Reset weight_addr and bias_addr to 0. Both increment linearly across the entire run and never reset per layer.
- Per-layer sizing: layer l has I_l inputs, where I_0 = cfg_num_inputs and I_l = N_(l-1) otherwise. Chunk count C_l = ceil(I_l/PAR).
- FSM states: IDLE, FETCH, FINAL, LAYER, DONE.
- FETCH (C_l cycles per neuron):
  - Issue weight_ren for chunk k; weight_addr increments after each issue.
  - Accumulate chunk k-1 in the same cycle.
  - On the last chunk, also assert bias_ren; bias_addr increments once per neuron.
- FINAL (1 cycle):
  - Accumulate chunk C_l-1, add the sign-extended bias, and write activation bit = (sum >= 0) into the other buffer.
  - Clear the accumulator, then go to FETCH for the next neuron, or to LAYER after the last neuron.
- Lane decode:
  - Lane j of chunk k uses bits [2j+1:2j] and input index k*PAR+j.
  - Weight encoding: 01 = +1, 11 = -1, 00 or 10 = 0.
  - Product = weight times activation (±1).
  - Lanes with index >= I_l contribute 0.
- LAYER (1 cycle): swap the ping-pong buffers; go to FETCH for the next layer, or to DONE after the last layer.
- Final layer argmax:
  - Track the running max of the sum; ties keep the lower index.
  - Load class_idx and class_score in FINAL of the last neuron; both hold until the next run finishes.
- DONE: assert done for 1 cycle, deassert busy, return to IDLE.
- Latency: with start accepted at cycle 0, done is high at cycle 1 + Σ_l (N_l*(C_l+1) + 1).
- Arithmetic: accumulation wraps modulo 2^ACC_WIDTH; no saturation.
- Reset mid-run: abort immediately and return to the reset state.

Optional Feature:
- Macro: TERNARY_MLP_ABORT_EN.
- With the macro defined, start=1 while busy aborts the run and restarts it the next cycle:
  - Re-latch in_vec and cfg_*, and reset the addresses.
  - done is not pulsed for the aborted run, and class outputs are unchanged.
- Without the macro, start while busy is ignored.

Test Plan:
- Reset: drive rst=0 mid-run, release, then check all outputs are 0, state is IDLE, and weight_ren/bias_ren are 0.
- Baseline (MAX_NEURONS=8, PAR=4, NUM_LAYERS=2, I=8, N={2,3}, all weights 01, bias 00, in_vec=8'hFF):
  - Layer-0 sums are 8, so both activations are 1.
  - Final-layer sums are all 2, so the result is class_idx=0, class_score=2.
  - done is high at cycle 15 (1 + 7 + 7).
  - weight_addr sequence is 0..6 and bias_addr sequence is 0..4.
- Padding mask: I=5, weights all 11, in_vec=0 → layer-0 sum=5; lanes 5-7 contribute 0 even though their data is nonzero.
- Bias/threshold: layer-0 sum 2 with bias 10 (-2) → sum 0, activation 1. Sum 1 with bias -2 → activation 0.
- Argmax: final-layer biases give scores {-1,3,3} → class_idx=1, class_score=3. The outputs hold after done until the next run's done.
- Busy start: start pulsed at cycle 5 of a run.
  - Without the macro: ignored, done at cycle 15.
  - With TERNARY_MLP_ABORT_EN: addresses restart at 0, and done arrives 15 cycles after the restart.
